// File: rtl/fir_shift_add_mult_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fir_shift_add_mult_pkg
// Description : Shared definitions for the FIR tap shift-and-add multiplier.
//               Holds the default datapath width and the sequencer state
//               encoding used by the top level.
// Revision    : 1.0 - initial release
// ============================================================================
package fir_shift_add_mult_pkg;

  // Default operand width for the tap datapath.
  localparam int FIR_DW = 8;

  // Sequencer states. The spare code 2'd3 is never entered; if it ever
  // appears, the next-state logic steers it back to ST_IDLE.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage : fir_shift_add_mult_pkg
`default_nettype wire

// File: rtl/fir_shift_add_mult_if.sv
`default_nettype none
// ============================================================================
// Module      : fir_shift_add_mult_if
// Description : Valid/ready operand and product bundle for the multiplier.
//   in_valid  : operand pair on a/b is valid        (master -> slave)
//   in_ready  : multiplier can accept a pair        (slave  -> master)
//   a, b      : multiplicand / multiplier, unsigned (master -> slave)
//   out_valid : product is valid                    (slave  -> master)
//   out_ready : downstream accepts the product      (master -> slave)
//   product   : a*b, 2*WIDTH bits, unsigned         (slave  -> master)
// Revision    : 1.0 - initial release
// ============================================================================
interface fir_shift_add_mult_if
  import fir_shift_add_mult_pkg::*;
#(
  parameter int WIDTH = FIR_DW
);

  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] product;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, product
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, product
  );

endinterface : fir_shift_add_mult_if
`default_nettype wire

// File: rtl/fir_shift_add_mult_rca_w.sv
`default_nettype none
// ============================================================================
// Module      : fir_shift_add_mult_rca_w
// Description : WIDTH-bit ripple-carry adder built from full-adder cells.
//   x, y : addends
//   cin  : carry in
//   sum  : WIDTH-bit sum
//   cout : carry out of the MSB cell
// Revision    : 1.0 - initial release
// ============================================================================
module fir_shift_add_mult_rca_w #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH:0] w_carry;

  assign w_carry[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign sum[i]       = x[i] ^ y[i] ^ w_carry[i];
    assign w_carry[i+1] = (x[i] & y[i]) | (w_carry[i] & (x[i] ^ y[i]));
  end

  assign cout = w_carry[WIDTH];

endmodule : fir_shift_add_mult_rca_w
`default_nettype wire

// File: rtl/fir_shift_add_mult.sv
`default_nettype none
// ============================================================================
// Module      : fir_shift_add_mult
// Description : Sequential shift-and-add unsigned multiplier. One partial
//               product is folded in per clock using a single WIDTH-bit
//               ripple-carry adder; the result appears WIDTH edges after the
//               operands are accepted.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : slave side of the valid/ready operand/product bundle
// Revision    : 1.0 - initial release
// ============================================================================
module fir_shift_add_mult
  import fir_shift_add_mult_pkg::*;
#(
  parameter int WIDTH = FIR_DW,
  parameter int CNT_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  fir_shift_add_mult_if.slave   bus
);

  localparam logic [CNT_W-1:0] c_last_step = CNT_W'(WIDTH - 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]   r_mul;
  logic [WIDTH-1:0]   r_acc;
  logic [CNT_W-1:0]   r_cnt;
  logic [2*WIDTH-1:0] r_product;

  logic [WIDTH-1:0]   w_addend;
  logic [WIDTH-1:0]   w_sum;
  logic               w_cout;

  assign w_addend = r_mul[0] ? r_mcand : '0;

  fir_shift_add_mult_rca_w #(
    .WIDTH (WIDTH)
  ) u_rca (
    .x    (r_acc),
    .y    (w_addend),
    .cin  (1'b0),
    .sum  (w_sum),
    .cout (w_cout)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (bus.in_valid)            w_state_nxt = ST_CALC;
      ST_CALC: if (r_cnt == c_last_step)    w_state_nxt = ST_DONE;
      ST_DONE: if (bus.out_ready)           w_state_nxt = ST_IDLE;
      default:                              w_state_nxt = ST_IDLE;
    endcase
  end

  // Datapath: {acc,mul} is one 2*WIDTH shift register. Each CALC step adds
  // the multiplicand into the upper half when the current multiplier LSB is
  // set, then shifts right by one with the adder carry entering at the top.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mcand   <= '0;
      r_mul     <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_product <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            r_mcand <= bus.a;
            r_mul   <= bus.b;
            r_acc   <= '0;
            r_cnt   <= '0;
          end
        end
        ST_CALC: begin
          r_acc <= {w_cout, w_sum[WIDTH-1:1]};
          r_mul <= {w_sum[0], r_mul[WIDTH-1:1]};
          r_cnt <= r_cnt + CNT_W'(1);
          // Capture the final shifted value into a separate register so
          // the product survives the next accept clearing acc/mul.
          if (r_cnt == c_last_step) begin
            r_product <= {w_cout, w_sum, r_mul[WIDTH-1:1]};
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == ST_IDLE);
  assign bus.out_valid = (r_state == ST_DONE);
  assign bus.product   = r_product;

endmodule : fir_shift_add_mult
`default_nettype wire

// File: tb/tb_fir_shift_add_mult.sv
`default_nettype none
// ============================================================================
// Module      : tb_fir_shift_add_mult
// Description : Self-checking bench for the shift-and-add multiplier.
//               Directed cases plus a randomized handshake run compared
//               against an arithmetic reference (product = a*b, result
//               visible WIDTH edges after accept).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fir_shift_add_mult;

  localparam int WIDTH = 8;

  logic clk;
  logic rst;
  int   n_total;
  int   n_bad;

  fir_shift_add_mult_if #(.WIDTH(WIDTH)) bus ();

  fir_shift_add_mult #(
    .WIDTH (WIDTH),
    .CNT_W (4)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready",  32'(bus.in_ready),  32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_product",   32'(bus.product),   32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_ready();
    for (int k = 0; k < 50; k++) begin
      if (bus.in_ready) break;
      @(posedge clk);
      #1;
    end
    check("wait_in_ready", 32'(bus.in_ready), 32'd1);
  endtask

  // One transaction; hold>0 keeps out_ready low for that many cycles of
  // DONE while spurious in_valid pulses are presented.
  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input int hold);
    int          lat;
    int          low;
    logic [15:0] exp;
    exp           = 16'(a) * 16'(b);
    bus.out_ready = (hold == 0);
    wait_ready();
    bus.a        = a;
    bus.b        = b;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    lat = 0;
    low = 0;
    while (!bus.out_valid && lat < 40) begin
      if (!bus.in_ready) low++;
      @(posedge clk);
      #1;
      lat++;
    end
    if (!bus.in_ready) low++;
    check({tag, "_latency"}, 32'(lat), 32'(WIDTH));
    check({tag, "_product"}, 32'(bus.product), 32'(exp));
    for (int h = 0; h < hold; h++) begin
      bus.in_valid = 1'b1;
      bus.a        = 8'($urandom);
      bus.b        = 8'($urandom);
      @(posedge clk);
      #1;
      if (!bus.in_ready) low++;
      check({tag, "_hold_valid"},   32'(bus.out_valid), 32'd1);
      check({tag, "_hold_product"}, 32'(bus.product),   32'(exp));
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check({tag, "_ready_low_cycles"}, 32'(low), 32'(WIDTH + 1 + hold));
    check({tag, "_handoff_valid"},    32'(bus.out_valid), 32'd0);
    check({tag, "_handoff_ready"},    32'(bus.in_ready),  32'd1);
    check({tag, "_product_kept"},     32'(bus.product),   32'(exp));
    bus.out_ready = 1'b0;
  endtask

  // Randomized back-to-back run. The model only knows: an accept happens
  // when in_valid meets an idle block, the product a*b is shown WIDTH edges
  // later, and it is released when out_ready meets a shown product.
  task automatic random_run(input int n_ops);
    bit          m_busy;
    int          m_age;
    logic [15:0] m_exp;
    int          n_done;
    int          cyc;
    bit          exp_ready;
    bit          exp_valid;
    m_busy = 1'b0;
    m_age  = 0;
    m_exp  = '0;
    n_done = 0;
    cyc    = 0;
    while (n_done < n_ops && cyc < 40000) begin
      @(negedge clk);
      cyc++;
      exp_ready = !m_busy;
      exp_valid = m_busy && (m_age >= WIDTH);
      check("rnd_in_ready",  32'(bus.in_ready),  32'(exp_ready));
      check("rnd_out_valid", 32'(bus.out_valid), 32'(exp_valid));
      if (exp_valid) check("rnd_product", 32'(bus.product), 32'(m_exp));
      bus.in_valid  = ($urandom_range(0, 9) < 7);
      bus.a         = 8'($urandom);
      bus.b         = 8'($urandom);
      bus.out_ready = $urandom_range(0, 1) == 1;
      if (!m_busy) begin
        if (bus.in_valid) begin
          m_busy = 1'b1;
          m_age  = 0;
          m_exp  = 16'(bus.a) * 16'(bus.b);
        end
      end else if (exp_valid && bus.out_ready) begin
        m_busy = 1'b0;
        n_done++;
      end else begin
        m_age++;
      end
    end
    check("rnd_ops_done", 32'(n_done), 32'(n_ops));
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
  endtask

  initial begin
    n_total       = 0;
    n_bad         = 0;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b0;
    do_reset();

    run_op("m13x11",  8'd13,  8'd11,  0);
    run_op("m255sq",  8'd255, 8'd255, 0);
    run_op("m0x200",  8'd0,   8'd200, 0);
    run_op("m200x0",  8'd200, 8'd0,   0);
    run_op("m7x9",    8'd7,   8'd9,   5);

    // Asynchronous reset in the 4th CALC cycle; product is non-zero here.
    bus.out_ready = 1'b0;
    wait_ready();
    bus.a        = 8'd100;
    bus.b        = 8'd50;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_in_ready",  32'(bus.in_ready),  32'd1);
    check("async_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("async_rst_product",   32'(bus.product),   32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    run_op("m3x5", 8'd3, 8'd5, 0);

    random_run(1000);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule : tb_fir_shift_add_mult
`default_nettype wire
